id_queue: RTL

- Parametrised instruction buffer with field decode, between fetch (IF) and decode (ID) in the pipelined MIPS core.
- Accepts fetched instruction/PC pairs on a valid/ready handshake and stores them in a DEPTH-entry circular FIFO.
- Presents the head entry pre-split into MIPS fields (opcode, rs, rt, rd, shamt, funct, imm, ins_index) with its PC.
- Supports a pipeline flush, used on branch/jump redirect.

---
 rtl/id_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/id_queue.sv
// IF->ID instruction buffer: DEPTH-entry FIFO of {instr, pc}, head pre-split into MIPS fields (ID_QUEUE_CLASS_EN adds out_class).
// Latency: an entry pushed at edge N is visible on out_* after edge N; no same-cycle bypass.
// Backpressure: in_ready = !full, independent of out_ready (no push-through when full); flush drops everything.
module id_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [PC_W-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [PC_W-1:0]         out_pc,
    output logic [5:0]              out_opcode,
    output logic [4:0]              out_rs,
    output logic [4:0]              out_rt,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_shamt,
    output logic [5:0]              out_funct,
    output logic [15:0]             out_imm,
    output logic [25:0]             out_ins_index,
`ifdef ID_QUEUE_CLASS_EN
    output logic [2:0]              out_class,
`endif
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    entry_t        head;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage is deliberately not reset; out_* are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_comb begin
        head = mem[rd_ptr];
        if (!out_valid) begin
            head = '0;
        end
    end

    assign out_instr     = head.instr;
    assign out_pc        = head.pc;
    assign out_opcode    = head.instr[31:26];
    assign out_rs        = head.instr[25:21];
    assign out_rt        = head.instr[20:16];
    assign out_rd        = head.instr[15:11];
    assign out_shamt     = head.instr[10:6];
    assign out_funct     = head.instr[5:0];
    assign out_imm       = head.instr[15:0];
    assign out_ins_index = head.instr[25:0];

`ifdef ID_QUEUE_CLASS_EN
    // One-hot: bit0 R-type, bit1 I-type, bit2 J-type (j/jal).
    always_comb begin
        out_class = 3'b000;
        if (out_valid) begin
            case (out_opcode)
                6'h00:        out_class = 3'b001;
                6'h02, 6'h03: out_class = 3'b100;
                default:      out_class = 3'b010;
            endcase
        end
    end
`endif

endmodule
